vga_mode_controller: RTL and testbench
======================================

// Module: vga_mode_controller
// PURPOSE
//  Sequences the 4-bit layer/mode select that drives the VGA compositing mux.
//  Debounces two user buttons that step the base-video mode (sel[1:0]) and the
//  overlay mode (sel[3:2]). Commits changes only at frame boundaries, so a
//  frame never mixes modes. Also schedules a frame-counted "hit flash" that
//  forces the overlay to the test colour (sel[3:2]=2'b11).
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  cycles a synced button must hold a new level before it is accepted (>=2)
//  FLASH_FRAMES     8          frames the hit flash lasts; 0 disables the flash
//  DEFAULT_SEL      4'b0100    select value after reset; [3:2] must not be 2'b11
// PORTS
//  clk_pixel_in      in   1  pixel clock; sole clock domain
//  rst_n_in          in   1  synchronous, active-low reset
//  btn_mode_in       in   1  raw asynchronous button; steps base mode sel[1:0]
//  btn_layer_in      in   1  raw asynchronous button; steps overlay mode sel[3:2]
//  new_frame_in      in   1  one-cycle pulse at the start of vertical blank
//  hit_in            in   1  one-cycle pulse from game logic; requests a flash
//  sel_out           out  4  registered select for the VGA mux
//  flash_active_out  out  1  high while the flash FSM is in FLASH
//  pending_out       out  1  high while pending select != committed select
// BEHAVIOUR
//  Reset (rst_n_in low at a clk edge):
//   - pending = active = DEFAULT_SEL; sel_out = DEFAULT_SEL.
//   - flash_active_out = 0; pending_out = 0.
//   - Sync flops, debounce counters, stable levels and flash counter clear to 0.
//   - FSM returns to IDLE. A reset mid-debounce or mid-flash discards all progress.
//  Input conditioning (per button):
//   - 2-flop synchroniser, then debounce.
//   - If synced != stable, count++; otherwise count = 0.
//   - When count == DEBOUNCE_CYCLES-1 and synced still differs, stable <= synced and count = 0.
//   - A press is one cycle high on a 0->1 edge of stable. Releases generate nothing.
//  Pending select:
//   - Mode press: pending[1:0] increments, 3 wraps to 0.
//   - Layer press: pending[3:2] steps 00->01->10->00. It never takes 11, which is reserved for the flash.
//   - Both presses in the same cycle: both fields update.
//  Commit:
//   - On new_frame_in, active <= pending as it stood before any same-cycle press.
//   - A same-cycle press lands in pending and commits on the next frame.
//   - pending_out is registered as (pending != active).
//  Flash FSM (states IDLE, ARMED, FLASH; ctr width $clog2(FLASH_FRAMES+1)):
//   - IDLE: hit_in -> ARMED. Ignored when FLASH_FRAMES == 0.
//   - ARMED: new_frame_in -> FLASH with ctr = FLASH_FRAMES. Further hits are absorbed.
//   - FLASH, on new_frame_in:
//     - if retrig is set: ctr = FLASH_FRAMES and retrig clears;
//     - else if ctr == 1: -> IDLE;
//     - else ctr--.
//   - FLASH, hit_in: sets retrig.
//   - hit_in coinciding with new_frame_in in IDLE: -> ARMED only; FLASH starts at the following frame.
//  Output:
//   - sel_out <= (next state == FLASH) ? {2'b11, active_next[1:0]} : active_next.
//   - sel_out therefore changes exactly one cycle after the new_frame_in pulse, and never between frame pulses.
//   - flash_active_out is registered alongside sel_out.
//  Latency, press to sel_out:
//   - 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles into pending;
//   - then the next new_frame_in + 1 cycle.
//  Boundaries:
//   - Button bounce shorter than DEBOUNCE_CYCLES produces no press.
//   - Held buttons produce a single press.
//   - new_frame_in held high for several cycles is illegal; behaviour is undefined.
// TESTING (bench uses DEBOUNCE_CYCLES=4, FLASH_FRAMES=3)
//  1. Reset:
//     - Drive rst_n_in=0 for 2 cycles, then release.
//     - Expect sel_out=4'b0100, flash_active_out=0, pending_out=0.
//  2. Mode press:
//     - Hold btn_mode_in=1 for 10 cycles, then pulse new_frame_in.
//     - Expect pending_out=1 before the frame pulse.
//     - One cycle after the pulse, expect sel_out=4'b0101 and pending_out=0.
//  3. Bounce and wrap:
//     - Toggle btn_mode_in every 2 cycles for 20 cycles: expect no change.
//     - Then make 4 clean mode presses plus a frame pulse: expect sel_out[1:0] back to 2'b00.
//  4. Layer wrap: make 2 layer presses plus a frame pulse from 01. Expect sel_out[3:2]=00, never 11.
//  5. Flash sequence from sel=4'b0100:
//     - Pulse hit_in, then apply 4 frame pulses.
//     - Expect sel_out=4'b1100 after frames 1-3 with flash_active_out=1.
//     - Expect sel_out=4'b0100 after frame 4.
//  6. Flash retrigger and reset:
//     - Pulse hit_in during FLASH at ctr=1: expect 3 more flash frames.
//     - Assert rst_n_in mid-flash: expect flash_active_out=0 and sel_out=4'b0100 the next cycle.

Source files
------------

// File: rtl/vga_mode_controller.sv
// Layer/mode select sequencer for the VGA compositing mux: debounced mode/layer buttons,
// frame-aligned commit, and a frame-counted hit flash that overrides the overlay field.
module vga_mode_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter logic [3:0]  DEFAULT_SEL     = 4'b0100
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       btn_mode_in,
    input  logic       btn_layer_in,
    input  logic       new_frame_in,
    input  logic       hit_in,
    output logic [3:0] sel_out,
    output logic       flash_active_out,
    output logic       pending_out
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CtrW = (FLASH_FRAMES == 0) ? 1 : $clog2(FLASH_FRAMES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CtrW-1:0] CtrLoad = CtrW'(FLASH_FRAMES);

    typedef enum logic [1:0] {StIdle, StArmed, StFlash} flash_state_e;

    // Bit 0 = mode button, bit 1 = layer button
    logic [1:0]      sync1_q, sync2_q, stable_q, stable_prev_q, press;
    logic [CntW-1:0] count_q [2];

    logic [3:0]      pending_q, pending_d, active_q, active_d;
    flash_state_e    state_q, state_d;
    logic [CtrW-1:0] ctr_q, ctr_d;
    logic            retrig_q, retrig_d;

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            count_q[0]    <= '0;
            count_q[1]    <= '0;
        end else begin
            sync1_q       <= {btn_layer_in, btn_mode_in};
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] != stable_q[b]) begin
                    if (count_q[b] == CntMax) begin
                        stable_q[b] <= sync2_q[b];
                        count_q[b]  <= '0;
                    end else begin
                        count_q[b] <= count_q[b] + CntW'(1);
                    end
                end else begin
                    count_q[b] <= '0;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // Commit takes the pre-press pending value; a same-cycle press waits for the next frame
    always_comb begin
        active_d  = new_frame_in ? pending_q : active_q;
        pending_d = pending_q;
        if (press[0]) begin
            pending_d[1:0] = pending_q[1:0] + 2'd1;
        end
        if (press[1]) begin
            pending_d[3:2] = (pending_q[3:2] >= 2'b10) ? 2'b00 : pending_q[3:2] + 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        retrig_d = retrig_q;
        case (state_q)
            StIdle: begin
                if (hit_in && FLASH_FRAMES != 0) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (new_frame_in) begin
                    state_d = StFlash;
                    ctr_d   = CtrLoad;
                end
            end
            StFlash: begin
                if (new_frame_in) begin
                    if (retrig_q) begin
                        ctr_d    = CtrLoad;
                        retrig_d = hit_in;
                    end else if (ctr_q == CtrW'(1)) begin
                        state_d  = StIdle;
                        retrig_d = 1'b0;
                    end else begin
                        ctr_d    = ctr_q - CtrW'(1);
                        retrig_d = hit_in;
                    end
                end else if (hit_in) begin
                    retrig_d = 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                retrig_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            pending_q        <= DEFAULT_SEL;
            active_q         <= DEFAULT_SEL;
            state_q          <= StIdle;
            ctr_q            <= '0;
            retrig_q         <= 1'b0;
            sel_out          <= DEFAULT_SEL;
            flash_active_out <= 1'b0;
            pending_out      <= 1'b0;
        end else begin
            pending_q        <= pending_d;
            active_q         <= active_d;
            state_q          <= state_d;
            ctr_q            <= ctr_d;
            retrig_q         <= retrig_d;
            sel_out          <= (state_d == StFlash) ? {2'b11, active_d[1:0]} : active_d;
            flash_active_out <= (state_d == StFlash);
            pending_out      <= (pending_d != active_d);
        end
    end

endmodule

// File: tb/tb_vga_mode_controller.sv
// Bench for vga_mode_controller: directed scenarios plus randomized traffic against a
// frame/press-level reference model.
module tb_vga_mode_controller;

    localparam int unsigned DC = 4;
    localparam int unsigned FF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_layer = 1'b0;
    logic       new_frame = 1'b0;
    logic       hit = 1'b0;
    logic [3:0] sel;
    logic       flash_active;
    logic       pending;

    int vectors = 0;
    int miscompares = 0;

    vga_mode_controller #(
        .DEBOUNCE_CYCLES(DC),
        .FLASH_FRAMES   (FF),
        .DEFAULT_SEL    (4'b0100)
    ) dut (
        .clk_pixel_in    (clk),
        .rst_n_in        (rst_n),
        .btn_mode_in     (btn_mode),
        .btn_layer_in    (btn_layer),
        .new_frame_in    (new_frame),
        .hit_in          (hit),
        .sel_out         (sel),
        .flash_active_out(flash_active),
        .pending_out     (pending)
    );

    always #5 clk = ~clk;

    // Reference model: button levels must persist DC synced cycles to count; mode counts
    // mod 4, layer mod 3; commit on frame; flash lasts FF frames, retriggerable.
    logic [1:0] m_s1, m_s2, m_stable, m_prev, m_press;
    int         m_run [2];
    int         m_pmode, m_player, m_amode, m_alayer, m_left;
    bit         m_armed, m_flash, m_retrig;
    logic [3:0] exp_sel;
    logic       exp_flash, exp_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_pmode = 0; m_player = 1; m_amode = 0; m_alayer = 1;
            m_armed = 0; m_flash = 0; m_left = 0; m_retrig = 0;
        end else begin
            m_press = m_stable & ~m_prev;
            m_prev  = m_stable;
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_stable[b] = m_s2[b];
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_layer, btn_mode};
            if (new_frame) begin
                m_amode  = m_pmode;
                m_alayer = m_player;
            end
            if (m_press[0]) m_pmode = (m_pmode + 1) % 4;
            if (m_press[1]) m_player = (m_player + 1) % 3;
            if (m_flash) begin
                if (new_frame) begin
                    if (m_retrig) begin
                        m_left = FF; m_retrig = hit;
                    end else if (m_left == 1) begin
                        m_flash = 0; m_retrig = 0;
                    end else begin
                        m_left--; m_retrig = hit;
                    end
                end else if (hit) begin
                    m_retrig = 1;
                end
            end else if (m_armed) begin
                if (new_frame) begin
                    m_armed = 0; m_flash = 1; m_left = FF;
                end
            end else if (hit) begin
                m_armed = 1;
            end
        end
        exp_flash = m_flash;
        exp_sel   = m_flash ? {2'b11, 2'(m_amode)} : {2'(m_alayer), 2'(m_amode)};
        exp_pend  = (m_pmode != m_amode) || (m_player != m_alayer);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (8) tick();
        btn_mode = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (sel !== 4'b0100 || flash_active !== 1'b0 || pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: sel=%b flash=%b pend=%b, want 0100/0/0", sel, flash_active,
                     pending);
        end
    endtask

    task automatic test_mode_press();
        btn_mode = 1'b1;
        repeat (10) tick();
        vectors++;
        if (pending !== 1'b1 || sel !== 4'b0100) begin
            miscompares++;
            $display("FAIL mode_pending: pend=%b sel=%b, want 1/0100", pending, sel);
        end
        frame();
        vectors++;
        if (sel !== 4'b0101 || pending !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_commit: sel=%b pend=%b, want 0101/0", sel, pending);
        end
        btn_mode = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_bounce_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_mode = ~btn_mode;
            repeat (2) tick();
        end
        btn_mode = 1'b0;
        repeat (8) tick();
        frame();
        vectors++;
        if (sel !== 4'b0100 || pending !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce: sel=%b pend=%b, want 0100/0", sel, pending);
        end
        press_mode();
        vectors++;
        if (pending !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_press1: pend=%b, want 1", pending);
        end
        repeat (3) press_mode();
        frame();
        vectors++;
        if (sel !== 4'b0100) begin
            miscompares++;
            $display("FAIL mode_wrap: sel=%b, want 0100", sel);
        end
    endtask

    task automatic test_layer_wrap();
        bit saw11 = 0;
        for (int p = 0; p < 2; p++) begin
            btn_layer = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (i == 8) btn_layer = 1'b0;
                tick();
                if (sel[3:2] == 2'b11) saw11 = 1;
            end
            if (p == 0) begin
                frame();
                vectors++;
                if (sel !== 4'b1000) begin
                    miscompares++;
                    $display("FAIL layer_step: sel=%b, want 1000", sel);
                end
            end
        end
        frame();
        vectors++;
        if (sel !== 4'b0000) begin
            miscompares++;
            $display("FAIL layer_wrap: sel=%b, want 0000", sel);
        end
        vectors++;
        if (saw11 !== 1'b0) begin
            miscompares++;
            $display("FAIL layer_never11: saw11=%b, want 0", saw11);
        end
    endtask

    task automatic test_flash();
        do_reset();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            repeat (3) tick();
            vectors++;
            if (f > 1 && f <= 4 && (sel !== 4'b1100 || flash_active !== 1'b1)) begin
                miscompares++;
                $display("FAIL flash_hold%0d: sel=%b flash=%b, want 1100/1", f, sel,
                         flash_active);
            end
            frame();
            vectors++;
            if (f <= 3 && (sel !== 4'b1100 || flash_active !== 1'b1)) begin
                miscompares++;
                $display("FAIL flash_frame%0d: sel=%b flash=%b, want 1100/1", f, sel,
                         flash_active);
            end else if (f == 4 && (sel !== 4'b0100 || flash_active !== 1'b0)) begin
                miscompares++;
                $display("FAIL flash_end: sel=%b flash=%b, want 0100/0", sel, flash_active);
            end
        end
    endtask

    task automatic test_retrigger_reset();
        do_reset();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int f = 1; f <= 7; f++) begin
            repeat (3) tick();
            if (f == 4) begin
                hit = 1'b1;
                tick();
                hit = 1'b0;
            end
            frame();
            vectors++;
            if ((f <= 6) !== flash_active || sel !== (f <= 6 ? 4'b1100 : 4'b0100)) begin
                miscompares++;
                $display("FAIL retrig_frame%0d: sel=%b flash=%b", f, sel, flash_active);
            end
        end
        hit = 1'b1;
        tick();
        hit = 1'b0;
        frame();
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (flash_active !== 1'b0 || sel !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_midflash: sel=%b flash=%b, want 0100/0", sel, flash_active);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int  hold_m = 0, hold_l = 0;
        bit  prev_frame = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if (hold_m == 0) begin
                btn_mode = ~btn_mode;
                hold_m   = $urandom_range(1, 12);
            end
            if (hold_l == 0) begin
                btn_layer = ~btn_layer;
                hold_l    = $urandom_range(1, 12);
            end
            hold_m--;
            hold_l--;
            new_frame  = !prev_frame && ($urandom_range(0, 9) == 0);
            hit        = !new_frame && ($urandom_range(0, 11) == 0);
            prev_frame = new_frame;
            tick();
            vectors++;
            if (sel !== exp_sel || flash_active !== exp_flash || pending !== exp_pend) begin
                miscompares++;
                $display("FAIL random c=%0d: sel=%b flash=%b pend=%b, want %b/%b/%b", c, sel,
                         flash_active, pending, exp_sel, exp_flash, exp_pend);
            end
        end
        rst_n = 1'b1;
        new_frame = 1'b0;
        hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_press();
        test_bounce_wrap();
        test_layer_wrap();
        test_flash();
        test_retrigger_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
